// File: rtl/edge_uart_tx_if.sv
// Pixel-in / UART-out signal bundle between the Sobel stage and edge_uart_tx.
interface edge_uart_tx_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        frame_end;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic        frame_done;
  logic [15:0] sent_count;

  modport master (
    output pix_in, pix_valid, frame_end,
    input  tx, busy, fifo_full, overflow, frame_done, sent_count
  );

  modport slave (
    input  pix_in, pix_valid, frame_end,
    output tx, busy, fifo_full, overflow, frame_done, sent_count
  );
endinterface

// File: rtl/edge_uart_tx.sv
// Sobel output stage: pixel FIFO feeding a UART 8N1 transmitter with frame-drain pulse.
// Optional macro EDGE_THRESH_EN binarises stored pixels against THRESH.
module edge_uart_tx #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned THRESH     = 200
) (
  input  logic           clk,
  input  logic           rstn,
  edge_uart_tx_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  if (BAUD_DIV < 4 || BAUD_DIV > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || THRESH > 255) begin : g_bad_param
    $error("edge_uart_tx: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_pop, w_char_done;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_fifo_full, r_overflow;
  logic              w_full, w_empty, w_push, w_drop;
  logic [7:0]        w_store;

  logic              r_fe_d, r_done_arm, r_frame_done;
  logic              w_fe_rise, w_done_fire;
  logic [15:0]       r_sent_count;

`ifdef EDGE_THRESH_EN
  assign w_store = (32'(bus.pix_in) >= THRESH) ? 8'hFF : 8'h00;
`else
  assign w_store = bus.pix_in;
`endif

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign w_push      = bus.pix_valid & (~w_full | w_pop);
  assign w_drop      = bus.pix_valid & ~w_push;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_store;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_fifo_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_fifo_full <= (w_count_nxt == CNT_FULL);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Transmit FSM state and registered line outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_char_done = 1'b0;
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_tmr_nxt   = TMR_LOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = TMR_LOAD;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      S_DATA: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = TMR_LOAD;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      S_STOP: begin
        if (r_tmr == '0) begin
          w_char_done = 1'b1;
          // The idle decision is taken on the stop-exit edge so queued pixels follow with no gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_tmr_nxt   = TMR_LOAD;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign w_fe_rise   = bus.frame_end & ~r_fe_d;
  assign w_done_fire = r_done_arm & w_empty & (r_state == S_IDLE) & ~bus.pix_valid;

  // Frame-end latch, drain pulse and character counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fe_d       <= 1'b0;
      r_done_arm   <= 1'b0;
      r_frame_done <= 1'b0;
      r_sent_count <= '0;
    end else begin
      r_fe_d       <= bus.frame_end;
      r_frame_done <= w_done_fire;
      if (w_fe_rise)        r_done_arm <= 1'b1;
      else if (w_done_fire) r_done_arm <= 1'b0;
      if (w_char_done) r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.fifo_full  = r_fifo_full;
  assign bus.overflow   = r_overflow;
  assign bus.frame_done = r_frame_done;
  assign bus.sent_count = r_sent_count;

endmodule

// File: tb/tb_edge_uart_tx.sv
// Self-checking bench for edge_uart_tx: line decoder plus queue-based pixel model.
module tb_edge_uart_tx;

  localparam int unsigned BD    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned THR   = 200;
  localparam int unsigned FL    = 10 * BD;

  logic clk;
  logic rstn;
  edge_uart_tx_if bus();

  edge_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .THRESH(THR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_sent = 0;
  int unsigned rx_idx   = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: frames found on tx, sampled mid-bit at the falling clock edge.
  logic [7:0]  rx_q [$];
  int unsigned start_q [$];
  int unsigned end_q [$];
  bit          m_in = 1'b0;
  int unsigned m_cnt = 0;
  logic [7:0]  m_byte = 8'h00;
  int unsigned m_err = 0;
  int unsigned fd_hi = 0;
  int unsigned fd_last = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      m_in = 1'b0;
    end else if (!m_in) begin
      if (bus.tx === 1'b0) begin
        m_in  = 1'b1;
        m_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (bus.busy !== 1'b1) m_err = m_err + 1;
      if (m_cnt == BD / 2 && bus.tx !== 1'b0) m_err = m_err + 1;
      if (m_cnt >= BD + BD / 2 && m_cnt < 9 * BD && ((m_cnt - BD / 2) % BD) == 0)
        m_byte[3'((m_cnt - BD / 2) / BD - 1)] = bus.tx;
      if (m_cnt == 9 * BD + BD / 2 && bus.tx !== 1'b1) m_err = m_err + 1;
      if (m_cnt == FL - 1) begin
        rx_q.push_back(m_byte);
        end_q.push_back(cyc);
        m_in = 1'b0;
      end
    end
    if (rstn && bus.frame_done === 1'b1) begin
      fd_hi   = fd_hi + 1;
      fd_last = cyc;
    end
  end

  function automatic logic [7:0] model(input logic [7:0] p);
`ifdef EDGE_THRESH_EN
    return (32'(p) >= THR) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  task automatic send_burst(input logic [7:0] v [8], input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = v[i];
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_rx(input int unsigned target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (rx_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (rx_q.size() >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;
    bus.frame_end = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", bus.tx); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.fifo_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.fifo_full); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.overflow); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_fd: got %b expected 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.sent_count !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.sent_count); else n_pass++;
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL idle_tx: got %b expected 1", bus.tx); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0]  b;
    int unsigned off;
    int unsigned e0;
    b  = 8'hA5;
    e0 = m_err;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_in    = b;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL single_pre: got %b expected 1", bus.tx); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.tx !== 1'b0) $display("FAIL single_start: got %b expected 0", bus.tx); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", bus.busy); else n_pass++;
    off = 0;
    for (int k = 0; k < 8; k++) begin
      repeat (BD * (k + 1) + 1 - off) @(negedge clk);
      off = BD * (k + 1) + 1;
      n_checks++;
      if (bus.tx !== model(b)[3'(k)]) $display("FAIL single_bit%0d: got %b expected %b", k, bus.tx, model(b)[3'(k)]);
      else n_pass++;
    end
    repeat (9 * BD + 1 - off) @(negedge clk);
    off = 9 * BD + 1;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL single_stop: got %b expected 1", bus.tx); else n_pass++;
    repeat (FL - 1 - off) @(negedge clk);
    n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL single_cnt_early: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
    @(negedge clk);
    exp_sent++;
    n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL single_cnt: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_end: got %b expected 0", bus.busy); else n_pass++;
    n_checks++;
    if (rx_q.size() <= rx_idx) $display("FAIL single_rx: got no frame expected %h", model(b));
    else if (rx_q[rx_idx] !== model(b)) $display("FAIL single_rx: got %h expected %h", rx_q[rx_idx], model(b));
    else n_pass++;
    rx_idx++;
    n_checks++; if (m_err !== e0) $display("FAIL single_framing: got %0d errors expected %0d", m_err, e0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  v [8];
    int unsigned s0, e0;
    bit ok;
    v = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    s0 = start_q.size();
    e0 = m_err;
    send_burst(v, 3);
    wait_rx(rx_idx + 3, 3 * FL + 20, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL b2b_timeout: got %0d frames expected %0d", rx_q.size(), rx_idx + 3); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx_q[rx_idx + i] !== model(v[i])) $display("FAIL b2b_data%0d: got %h expected %h", i, rx_q[rx_idx + i], model(v[i]));
        else n_pass++;
      end
      n_checks++;
      if (start_q[s0 + 1] - start_q[s0] !== FL) $display("FAIL b2b_gap1: got %0d expected %0d", start_q[s0 + 1] - start_q[s0], FL); else n_pass++;
      n_checks++;
      if (start_q[s0 + 2] - start_q[s0 + 1] !== FL) $display("FAIL b2b_gap2: got %0d expected %0d", start_q[s0 + 2] - start_q[s0 + 1], FL); else n_pass++;
    end
    rx_idx += 3;
    exp_sent += 3;
    n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL b2b_cnt: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
    n_checks++; if (m_err !== e0) $display("FAIL b2b_framing: got %0d errors expected %0d", m_err, e0); else n_pass++;
  endtask

  task automatic test_thresh();
    logic [7:0] v [8];
    logic [7:0] e0, e1;
    bit ok;
`ifdef EDGE_THRESH_EN
    e0 = 8'h00; e1 = 8'hFF;
`else
    e0 = 8'hC7; e1 = 8'hC8;
`endif
    v = '{8'd199, 8'd200, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_burst(v, 2);
    wait_rx(rx_idx + 2, 2 * FL + 20, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL thr_timeout: got %0d frames expected %0d", rx_q.size(), rx_idx + 2); else n_pass++;
    if (ok) begin
      n_checks++; if (rx_q[rx_idx] !== e0) $display("FAIL thr_199: got %h expected %h", rx_q[rx_idx], e0); else n_pass++;
      n_checks++; if (rx_q[rx_idx + 1] !== e1) $display("FAIL thr_200: got %h expected %h", rx_q[rx_idx + 1], e1); else n_pass++;
    end
    rx_idx += 2;
    exp_sent += 2;
  endtask

  task automatic test_random();
    logic [7:0] v [8];
    int n;
    bit ok;
    for (int t = 0; t < 12; t++) begin
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
      send_burst(v, n);
      wait_rx(rx_idx + n, n * FL + 20, ok);
      repeat (3) @(negedge clk);
      n_checks++; if (!ok) $display("FAIL rnd_timeout: got %0d frames expected %0d", rx_q.size(), rx_idx + n); else n_pass++;
      if (ok) begin
        for (int i = 0; i < n; i++) begin
          n_checks++;
          if (rx_q[rx_idx + i] !== model(v[i])) $display("FAIL rnd_data: got %h expected %h", rx_q[rx_idx + i], model(v[i]));
          else n_pass++;
        end
      end
      rx_idx += n;
      exp_sent += n;
      n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL rnd_cnt: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL rnd_ovf: got %b expected 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] v [8];
    bit ok;
    for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = v[i];
      @(negedge clk);
      if (i == 4) begin
        n_checks++; if (bus.fifo_full !== 1'b1) $display("FAIL ovf_full: got %b expected 1", bus.fifo_full); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_early: got %b expected 0", bus.overflow); else n_pass++;
      end
    end
    bus.pix_valid = 1'b0;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", bus.overflow); else n_pass++;
    wait_rx(rx_idx + 5, 5 * FL + 40, ok);
    repeat (2 * FL) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL ovf_timeout: got %0d frames expected %0d", rx_q.size(), rx_idx + 5); else n_pass++;
    n_checks++; if (rx_q.size() !== rx_idx + 5) $display("FAIL ovf_frames: got %0d expected %0d", rx_q.size(), rx_idx + 5); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (rx_q[rx_idx + i] !== model(v[i])) $display("FAIL ovf_data%0d: got %h expected %h", i, rx_q[rx_idx + i], model(v[i]));
        else n_pass++;
      end
    end
    rx_idx = rx_q.size();
    exp_sent += 5;
    n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL ovf_cnt: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.fifo_full !== 1'b0) $display("FAIL ovf_drained: got %b expected 0", bus.fifo_full); else n_pass++;
  endtask

  task automatic test_frame_done();
    logic [7:0]  v [8];
    int unsigned fd0, ei, e;
    bit ok;
    for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
    fd0 = fd_hi;
    ei  = end_q.size();
    send_burst(v, 2);
    repeat (5) @(negedge clk);
    bus.frame_end = 1'b1;
    wait_rx(rx_idx + 2, 2 * FL + 20, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL fd_timeout: got %0d frames expected %0d", rx_q.size(), rx_idx + 2); else n_pass++;
    n_checks++; if (fd_hi - fd0 !== 1) $display("FAIL fd_pulse: got %0d high cycles expected 1", fd_hi - fd0); else n_pass++;
    if (ok) begin
      e = end_q[ei + 1];
      n_checks++;
      if (!(fd_last > e && fd_last <= e + 2)) $display("FAIL fd_timing: got cycle %0d expected %0d..%0d", fd_last, e + 1, e + 2);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (rx_q[rx_idx + i] !== model(v[i])) $display("FAIL fd_data%0d: got %h expected %h", i, rx_q[rx_idx + i], model(v[i]));
        else n_pass++;
      end
    end
    rx_idx += 2;
    exp_sent += 2;
    repeat (60) @(negedge clk);
    n_checks++; if (fd_hi - fd0 !== 1) $display("FAIL fd_held: got %0d high cycles expected 1", fd_hi - fd0); else n_pass++;
    bus.frame_end = 1'b0;
    repeat (3) @(negedge clk);
    bus.frame_end = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (fd_hi - fd0 !== 2) $display("FAIL fd_rearm: got %0d high cycles expected 2", fd_hi - fd0); else n_pass++;
    bus.frame_end = 1'b0;
    n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL fd_cnt: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0]  v [8];
    logic [7:0]  m;
    int unsigned s0;
    v = '{8'h3C, 8'h5A, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    m = model(v[0]);
    send_burst(v, 3);
    repeat (17) @(negedge clk);
    n_checks++; if (bus.tx !== m[3]) $display("FAIL mid_bit3: got %b expected %b", bus.tx, m[3]); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL mid_tx: got %b expected 1", bus.tx); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.sent_count !== 16'd0) $display("FAIL mid_cnt: got %0d expected 0", bus.sent_count); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL mid_ovf: got %b expected 0", bus.overflow); else n_pass++;
    n_checks++; if (bus.fifo_full !== 1'b0) $display("FAIL mid_full: got %b expected 0", bus.fifo_full); else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_sent = 0;
    s0 = start_q.size();
    repeat (3 * FL) @(negedge clk);
    n_checks++; if (start_q.size() !== s0) $display("FAIL mid_nostart: got %0d starts expected %0d", start_q.size(), s0); else n_pass++;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL mid_idle_tx: got %b expected 1", bus.tx); else n_pass++;
    n_checks++; if (bus.sent_count !== 16'(exp_sent)) $display("FAIL mid_cnt_after: got %0d expected %0d", bus.sent_count, exp_sent); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy_after: got %b expected 0", bus.busy); else n_pass++;
  endtask

  initial begin
    rstn          = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;
    bus.frame_end = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_thresh();
    test_random();
    test_overflow();
    test_frame_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
